// File: rtl/ddr_line_fetch_ctrl.sv
// ============================================================================
// ddr_line_fetch_ctrl - splits pixel-FIFO fill commands into DDR read bursts. Rev 1.0
// ============================================================================
`default_nettype none

module ddr_line_fetch_ctrl #(
    parameter logic [31:0] FILL_BYTES  = 32'h00000280,
    parameter int          BURST_BYTES = 64,
    parameter int          FIFO_AW     = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 go_fill_I,
    input  logic [31:0]          fill_addr_I,
    input  logic                 abort_I,
    input  logic [FIFO_AW:0]     fifo_count_I,
    output logic                 rd_req_O,
    output logic [31:0]          rd_addr_O,
    output logic [11:0]          rd_len_O,
    input  logic                 rd_ack_I,
    input  logic                 rd_valid_I,
    input  logic                 rd_done_I,
    input  logic                 rd_err_I,
    output logic                 fifo_wr_en_O,
    output logic                 busy_O,
    output logic                 overflow_O,
    output logic                 err_O
);

    localparam logic [31:0] BURST_C    = 32'(BURST_BYTES);
    localparam logic [31:0] FIFO_DEPTH = 32'd1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        REQ   = 3'd2,
        DATA  = 3'd3,
        NEXT  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        pending, pending_nxt;
    logic [31:0] pend_addr, pend_addr_nxt;
    logic [31:0] cur_addr;
    logic [31:0] remaining;
    logic [11:0] beat_cnt;
    logic        bad_seen;
    logic        aborted;
    logic        lost;

    logic [31:0] len;
    logic [31:0] len_words;
    logic [31:0] count_ext;
    logic [31:0] free_words;
    logic        space_ok;
    logic [11:0] beats_total;
    logic        burst_bad;
    logic        start_fill;
    logic        direct;
    logic        consume;
    logic [31:0] fill_addr_al;

    assign len          = (remaining < BURST_C) ? remaining : BURST_C;
    assign len_words    = len >> 2;
    assign count_ext    = {{(31 - FIFO_AW){1'b0}}, fifo_count_I};
    assign free_words   = FIFO_DEPTH - count_ext;
    assign space_ok     = (count_ext <= FIFO_DEPTH) && (free_words >= len_words);
    assign beats_total  = beat_cnt + {11'd0, rd_valid_I};
    assign burst_bad    = ({20'd0, beats_total} != len_words) || bad_seen || rd_err_I;
    assign fill_addr_al = fill_addr_I & 32'hFFFF_FFFC;

    // A queued command always wins over a new one arriving in IDLE.
    assign start_fill = (state == IDLE) && start && !abort_I && (go_fill_I || pending);
    assign consume    = (state == IDLE) && start && !abort_I && pending;
    assign direct     = (state == IDLE) && start && !abort_I && go_fill_I && !pending;

    assign fifo_wr_en_O = (state == DATA) && rd_valid_I;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_fill) state_nxt = CHECK;
            CHECK: begin
                if (abort_I)
                    state_nxt = IDLE;
                else if (start && space_ok)
                    state_nxt = REQ;
            end
            REQ:   if (rd_ack_I)  state_nxt = DATA;
            DATA:  if (rd_done_I) state_nxt = NEXT;
            NEXT: begin
                // remaining == len also covers a fill cut short (remaining cleared to 0).
                if (aborted || abort_I || (remaining == len))
                    state_nxt = IDLE;
                else
                    state_nxt = CHECK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pending_nxt   = pending;
        pend_addr_nxt = pend_addr;
        lost          = 1'b0;
        if (abort_I) begin
            pending_nxt = go_fill_I;
            if (go_fill_I)
                pend_addr_nxt = fill_addr_al;
        end else begin
            if (consume)
                pending_nxt = 1'b0;
            if (go_fill_I && !direct) begin
                if (!pending || consume) begin
                    pending_nxt   = 1'b1;
                    pend_addr_nxt = fill_addr_al;
                end else begin
                    lost = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            pend_addr  <= 32'd0;
            cur_addr   <= 32'd0;
            remaining  <= 32'd0;
            beat_cnt   <= 12'd0;
            bad_seen   <= 1'b0;
            aborted    <= 1'b0;
            rd_req_O   <= 1'b0;
            rd_addr_O  <= 32'd0;
            rd_len_O   <= 12'd0;
            busy_O     <= 1'b0;
            overflow_O <= 1'b0;
            err_O      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            pend_addr <= pend_addr_nxt;
            busy_O    <= (state_nxt != IDLE) || pending_nxt;

            if (start_fill) begin
                cur_addr  <= pending ? pend_addr : fill_addr_al;
                remaining <= FILL_BYTES;
            end

            if ((state == CHECK) && (state_nxt == REQ)) begin
                rd_req_O  <= 1'b1;
                rd_addr_O <= cur_addr;
                rd_len_O  <= len[11:0];
                beat_cnt  <= 12'd0;
                bad_seen  <= 1'b0;
            end

            if ((state == REQ) && rd_ack_I)
                rd_req_O <= 1'b0;

            if (state == DATA) begin
                beat_cnt <= beats_total;
                if (rd_err_I)
                    bad_seen <= 1'b1;
                if (rd_done_I && burst_bad)
                    remaining <= 32'd0;
            end

            if (state == NEXT) begin
                cur_addr  <= cur_addr + len;
                remaining <= (aborted || abort_I) ? 32'd0 : (remaining - len);
            end

            if (state_nxt == IDLE)
                aborted <= 1'b0;
            else if (abort_I && ((state == REQ) || (state == DATA)))
                aborted <= 1'b1;

            if (!start)
                overflow_O <= 1'b0;
            else if (lost)
                overflow_O <= 1'b1;

            if (!start)
                err_O <= 1'b0;
            else if ((state == DATA) && rd_done_I && burst_bad)
                err_O <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr_line_fetch_ctrl.sv
// ============================================================================
// tb_ddr_line_fetch_ctrl - randomized bench with a burst-plan reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr_line_fetch_ctrl;

    localparam int BURST = 64;

    logic        clk = 1'b0;
    logic        reset, start, go, abort_s, ack, valid, done, rerr, sel;
    logic [31:0] faddr;
    logic [9:0]  fcount;

    logic        req0, wr0, busy0, ovf0, err0;
    logic [31:0] addr0;
    logic [11:0] len0;
    logic        req1, wr1, busy1, ovf1, err1;
    logic [31:0] addr1;
    logic [11:0] len1;

    wire        m_req  = sel ? req1  : req0;
    wire [31:0] m_addr = sel ? addr1 : addr0;
    wire [11:0] m_len  = sel ? len1  : len0;
    wire        m_wr   = sel ? wr1   : wr0;
    wire        m_busy = sel ? busy1 : busy0;
    wire        m_ovf  = sel ? ovf1  : ovf0;
    wire        m_err  = sel ? err1  : err0;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [31:0] plan_a[$];
    int          plan_l[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (m_wr) wr_cnt++;

    ddr_line_fetch_ctrl dut0 (
        .clk(clk), .reset(reset), .start(start),
        .go_fill_I(go & ~sel), .fill_addr_I(faddr), .abort_I(abort_s),
        .fifo_count_I(fcount),
        .rd_req_O(req0), .rd_addr_O(addr0), .rd_len_O(len0),
        .rd_ack_I(ack & ~sel), .rd_valid_I(valid & ~sel), .rd_done_I(done & ~sel),
        .rd_err_I(rerr & ~sel),
        .fifo_wr_en_O(wr0), .busy_O(busy0), .overflow_O(ovf0), .err_O(err0)
    );

    ddr_line_fetch_ctrl #(.FILL_BYTES(32'd100)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .go_fill_I(go & sel), .fill_addr_I(faddr), .abort_I(1'b0),
        .fifo_count_I(fcount),
        .rd_req_O(req1), .rd_addr_O(addr1), .rd_len_O(len1),
        .rd_ack_I(ack & sel), .rd_valid_I(valid & sel), .rd_done_I(done & sel),
        .rd_err_I(rerr & sel),
        .fifo_wr_en_O(wr1), .busy_O(busy1), .overflow_O(ovf1), .err_O(err1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a fill is cut into consecutive bursts of at most BURST bytes.
    task automatic plan(input logic [31:0] addr, input int fill);
        logic [31:0] a;
        int rem;
        a   = addr & 32'hFFFF_FFFC;
        rem = fill;
        while (rem > 0) begin
            plan_a.push_back(a);
            plan_l.push_back((rem < BURST) ? rem : BURST);
            a   = a + ((rem < BURST) ? rem : BURST);
            rem = rem - ((rem < BURST) ? rem : BURST);
        end
    endtask

    task automatic pulse_go(input logic [31:0] a);
        go = 1'b1; faddr = a;
        step();
        go = 1'b0;
    endtask

    task automatic do_burst(input logic [31:0] ea, input int el, input int beats,
                            input bit errp, input bit abrt);
        int t;
        bit tog;
        t = 0;
        while (m_req !== 1'b1 && t < 60) begin step(); t++; end
        check_val("req_seen", m_req, 1);
        if (m_req !== 1'b1) return;
        repeat ($urandom_range(0, 2)) step();
        check_val("rd_addr", m_addr, ea);
        check_val("rd_len", m_len, el);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_val("req_drop", m_req, 0);
        tog = 1'($urandom_range(0, 1));
        for (int i = 0; i < beats; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            valid   = 1'b1;
            rerr    = errp && (i == beats / 2);
            abort_s = abrt && (i == 1);
            done    = tog && (i == beats - 1);
            #1;
            check_val("wr_pass", m_wr, 1);
            step();
            valid = 1'b0; rerr = 1'b0; abort_s = 1'b0; done = 1'b0;
        end
        if (!tog) begin
            done = 1'b1;
            step();
            done = 1'b0;
        end
    endtask

    task automatic run_plan();
        for (int i = 0; i < plan_a.size(); i++)
            do_burst(plan_a[i], plan_l[i], plan_l[i] / 4, 1'b0, 1'b0);
        plan_a.delete();
        plan_l.delete();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (m_busy !== 1'b0 && t < 40) begin step(); t++; end
        check_val("busy_low", m_busy, 0);
    endtask

    task automatic no_req(input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            step();
            if (m_req !== 1'b0) hits++;
        end
        check_val("no_req", hits, 0);
    endtask

    task automatic clear_flags();
        start = 1'b0;
        step();
        start = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        logic [31:0] ra;
        reset = 1'b1; start = 1'b1; go = 1'b0; abort_s = 1'b0; ack = 1'b0;
        valid = 1'b0; done = 1'b0; rerr = 1'b0; sel = 1'b0; faddr = 32'd0; fcount = 10'd0;
        #1;
        check_val("rst_req", req0, 0);
        check_val("rst_busy", busy0, 0);
        check_val("rst_ovf", ovf0, 0);
        check_val("rst_err", err0, 0);
        check_val("rst_addr", addr0, 0);
        check_val("rst_wr", wr0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // Default fill into an empty FIFO.
        w0 = wr_cnt;
        pulse_go(32'hA800_0000);
        plan(32'hA800_0000, 640);
        check_val("plan_cnt", plan_a.size(), 10);
        run_plan();
        wait_idle();
        check_val("writes_640", wr_cnt - w0, 160);
        check_val("ovf_clean", m_ovf, 0);
        check_val("err_clean", m_err, 0);

        // Random addresses and FIFO levels with enough room.
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            fcount = 10'($urandom_range(0, 496));
            w0 = wr_cnt;
            pulse_go(ra);
            plan(ra, 640);
            run_plan();
            wait_idle();
            check_val("writes_rand", wr_cnt - w0, 160);
            fcount = 10'd0;
        end

        // Backpressure: 12 free words cannot take a 16-word burst.
        fcount = 10'd500;
        w0 = wr_cnt;
        pulse_go(32'hA800_0000);
        no_req(6);
        check_val("bp_busy", m_busy, 1);
        fcount = 10'd496;
        step();
        step();
        check_val("bp_release", m_req, 1);
        fcount = 10'd0;
        plan(32'hA800_0000, 640);
        run_plan();
        wait_idle();
        check_val("writes_bp", wr_cnt - w0, 160);

        // Command queue: second queued, third lost.
        w0 = wr_cnt;
        pulse_go(32'hA800_0000);
        plan(32'hA800_0000, 640);
        plan(32'hA800_0500, 640);
        for (int i = 0; i < plan_a.size(); i++) begin
            do_burst(plan_a[i], plan_l[i], plan_l[i] / 4, 1'b0, 1'b0);
            if (i == 1) pulse_go(32'hA800_0500);
            if (i == 2) begin
                pulse_go(32'hA800_0900);
                check_val("ovf_set", m_ovf, 1);
            end
        end
        plan_a.delete();
        plan_l.delete();
        wait_idle();
        check_val("writes_q", wr_cnt - w0, 320);
        check_val("ovf_sticky", m_ovf, 1);
        clear_flags();
        check_val("ovf_clear", m_ovf, 0);

        // Abort during DATA of burst 3 also drops the pending command.
        w0 = wr_cnt;
        pulse_go(32'hA800_0000);
        do_burst(32'hA800_0000, 64, 16, 1'b0, 1'b0);
        pulse_go(32'hB000_0000);
        do_burst(32'hA800_0040, 64, 16, 1'b0, 1'b0);
        do_burst(32'hA800_0080, 64, 16, 1'b0, 1'b1);
        no_req(20);
        check_val("abort_busy", m_busy, 0);
        check_val("writes_abort", wr_cnt - w0, 48);

        // Short burst.
        pulse_go(32'hA800_0000);
        do_burst(32'hA800_0000, 64, 15, 1'b0, 1'b0);
        no_req(20);
        check_val("err_short", m_err, 1);
        check_val("err_short_busy", m_busy, 0);
        clear_flags();
        check_val("err_clear", m_err, 0);

        // Bus error pulse.
        pulse_go(32'hA800_0000);
        do_burst(32'hA800_0000, 64, 16, 1'b1, 1'b0);
        no_req(20);
        check_val("err_bus", m_err, 1);
        check_val("err_bus_busy", m_busy, 0);
        clear_flags();

        // 100-byte fills on the second instance, including address wrap.
        sel = 1'b1;
        step();
        w0 = wr_cnt;
        pulse_go(32'h0000_1000);
        plan(32'h0000_1000, 100);
        check_val("plan100_len", plan_l[1], 36);
        run_plan();
        wait_idle();
        check_val("writes_100", wr_cnt - w0, 25);
        w0 = wr_cnt;
        pulse_go(32'hFFFF_FFC0);
        plan(32'hFFFF_FFC0, 100);
        check_val("wrap_addr", plan_a[1], 32'h0000_0000);
        run_plan();
        wait_idle();
        check_val("writes_wrap", wr_cnt - w0, 25);
        check_val("err_100", m_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
